// File: rtl/noise_req_arbiter_if.sv
// Requester and generator handshake bundle for the shared noise-sample arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface noise_req_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int DW    = 64
);
   logic [N_REQ-1:0]   req;
   logic [2*N_REQ-1:0] req_mode;
   logic [N_REQ-1:0]   gnt;
   logic [DW-1:0]      rsp_data;
   logic               rsp_err;
   logic               gen_req;
   logic [1:0]         gen_mode;
   logic               gen_vld;
   logic [DW-1:0]      gen_data;

   modport slave (
      input  req, req_mode, gen_vld, gen_data,
      output gnt, rsp_data, rsp_err, gen_req, gen_mode
   );

   modport master (
      output req, req_mode, gen_vld, gen_data,
      input  gnt, rsp_data, rsp_err, gen_req, gen_mode
   );
endinterface

// File: rtl/noise_req_arbiter.sv
// Round-robin arbiter sharing one noise generator among N_REQ requesters,
// with a single outstanding transaction, a WAIT timeout and delivery statistics.
module noise_req_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DW      = 64,
   parameter int TIMEOUT = 64,
   parameter int CW      = 32
) (
   input  logic                clk,
   input  logic                rstb,
   noise_req_arbiter_if.slave  bus,
   output logic                busy,
   output logic [CW-1:0]       samp_cnt,
   output logic [CW-1:0]       tmo_cnt,
   output logic [7:0]          spur_cnt
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] DELIVER = 2'd3;

   logic [1:0]       state_r;
   logic [IW-1:0]    ptr_r;
   logic [IW-1:0]    idx_r;
   logic [TW-1:0]    timer_r;
   logic [N_REQ-1:0] gnt_r;
   logic [DW-1:0]    rsp_data_r;
   logic             rsp_err_r;
   logic             gen_req_r;
   logic [1:0]       gen_mode_r;
   logic             busy_r;
   logic [CW-1:0]    samp_cnt_r;
   logic [CW-1:0]    tmo_cnt_r;
   logic [7:0]       spur_cnt_r;

   logic             sel_vld_s;
   logic [IW-1:0]    sel_idx_s;
   logic [1:0]       sel_mode_s;
   int               cand_s;

   // Round-robin pick: first set request searching upward from ptr, wrapping.
   always_comb begin
      sel_vld_s  = 1'b0;
      sel_idx_s  = '0;
      sel_mode_s = 2'b00;
      cand_s     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand_s = (int'(ptr_r) + i) % N_REQ;
         if (!sel_vld_s && bus.req[cand_s]) begin
            sel_vld_s  = 1'b1;
            sel_idx_s  = IW'(cand_s);
            sel_mode_s = bus.req_mode[2*cand_s +: 2];
         end else begin
            sel_vld_s  = sel_vld_s;
         end
      end
   end

   // Transaction FSM, registered response/generator outputs and statistics.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r    <= IDLE;
         ptr_r      <= '0;
         idx_r      <= '0;
         timer_r    <= '0;
         gnt_r      <= '0;
         rsp_data_r <= '0;
         rsp_err_r  <= 1'b0;
         gen_req_r  <= 1'b0;
         gen_mode_r <= 2'b00;
         busy_r     <= 1'b0;
         samp_cnt_r <= '0;
         tmo_cnt_r  <= '0;
         spur_cnt_r <= 8'h00;
      end else begin
         gnt_r     <= '0;
         gen_req_r <= 1'b0;
         // Any response not awaited is dropped, including late ones after a timeout.
         if (bus.gen_vld && (state_r != WAIT) && (spur_cnt_r != 8'hFF)) begin
            spur_cnt_r <= spur_cnt_r + 8'h01;
         end else begin
            spur_cnt_r <= spur_cnt_r;
         end
         case (state_r)
            IDLE: begin
               if (sel_vld_s) begin
                  idx_r      <= sel_idx_s;
                  gen_req_r  <= 1'b1;
                  gen_mode_r <= sel_mode_s;
                  busy_r     <= 1'b1;
                  state_r    <= ISSUE;
               end else begin
                  state_r    <= IDLE;
               end
            end
            ISSUE: begin
               timer_r    <= '0;
               gen_mode_r <= 2'b00;
               state_r    <= WAIT;
            end
            WAIT: begin
               if (bus.gen_vld) begin
                  rsp_data_r <= bus.gen_data;
                  rsp_err_r  <= 1'b0;
                  gnt_r      <= {{(N_REQ-1){1'b0}}, 1'b1} << idx_r;
                  state_r    <= DELIVER;
               end else if (timer_r == TW'(TIMEOUT - 1)) begin
                  rsp_data_r <= '0;
                  rsp_err_r  <= 1'b1;
                  gnt_r      <= {{(N_REQ-1){1'b0}}, 1'b1} << idx_r;
                  state_r    <= DELIVER;
               end else begin
                  timer_r    <= timer_r + 1'b1;
               end
            end
            DELIVER: begin
               if (rsp_err_r) begin
                  if (tmo_cnt_r != {CW{1'b1}}) begin
                     tmo_cnt_r <= tmo_cnt_r + 1'b1;
                  end else begin
                     tmo_cnt_r <= tmo_cnt_r;
                  end
               end else begin
                  samp_cnt_r <= samp_cnt_r + 1'b1;
               end
               ptr_r      <= (idx_r == IW'(N_REQ - 1)) ? '0 : idx_r + 1'b1;
               rsp_data_r <= '0;
               rsp_err_r  <= 1'b0;
               busy_r     <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt      = gnt_r;
   assign bus.rsp_data = rsp_data_r;
   assign bus.rsp_err  = rsp_err_r;
   assign bus.gen_req  = gen_req_r;
   assign bus.gen_mode = gen_mode_r;
   assign busy         = busy_r;
   assign samp_cnt     = samp_cnt_r;
   assign tmo_cnt      = tmo_cnt_r;
   assign spur_cnt     = spur_cnt_r;
endmodule

// File: tb/tb_noise_req_arbiter.sv
// Directed self-checking bench for noise_req_arbiter (N_REQ=4, DW=64, TIMEOUT=64).
module tb_noise_req_arbiter;
   logic        clk;
   logic        rstb;
   logic        busy;
   logic [31:0] samp_cnt;
   logic [31:0] tmo_cnt;
   logic [7:0]  spur_cnt;
   int          tests;
   int          fails;

   noise_req_arbiter_if #(.N_REQ(4), .DW(64)) bus ();

   noise_req_arbiter #(.N_REQ(4), .DW(64), .TIMEOUT(64), .CW(32)) dut (
      .clk      (clk),
      .rstb     (rstb),
      .bus      (bus),
      .busy     (busy),
      .samp_cnt (samp_cnt),
      .tmo_cnt  (tmo_cnt),
      .spur_cnt (spur_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // From IDLE with req already set: ISSUE, WAIT (generator answers), DELIVER, back to IDLE.
   task automatic serve(input string tag, input logic [3:0] exp_gnt,
                        input logic [1:0] exp_mode, input logic [63:0] d);
      tick();
      chk({tag, ".gen_req"}, 64'(bus.gen_req), 64'd1);
      chk({tag, ".gen_mode"}, 64'(bus.gen_mode), 64'(exp_mode));
      chk({tag, ".gnt_early"}, 64'(bus.gnt), 64'd0);
      tick();
      bus.gen_vld  = 1'b1;
      bus.gen_data = d;
      tick();
      bus.gen_vld  = 1'b0;
      chk({tag, ".gnt"}, 64'(bus.gnt), 64'(exp_gnt));
      chk({tag, ".data"}, bus.rsp_data, d);
      chk({tag, ".err"}, 64'(bus.rsp_err), 64'd0);
      tick();
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      #1;
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      rstb         = 1'b0;
      bus.req      = 4'b0000;
      bus.req_mode = 8'h00;
      bus.gen_vld  = 1'b0;
      bus.gen_data = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.gnt", 64'(bus.gnt), 64'd0);
      chk("rst.gen_req", 64'(bus.gen_req), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.samp", 64'(samp_cnt), 64'd0);
      chk("rst.spur", 64'(spur_cnt), 64'd0);
      rstb = 1'b1;
      tick();

      // Single requester 2, mode 01.
      bus.req      = 4'b0100;
      bus.req_mode = 8'h10;
      serve("single", 4'b0100, 2'b01, 64'h3FF0000000000000);
      bus.req = 4'b0000;
      chk("single.gnt_off", 64'(bus.gnt), 64'd0);
      chk("single.data_off", bus.rsp_data, 64'd0);
      chk("single.samp", 64'(samp_cnt), 64'd1);
      chk("single.busy", 64'(busy), 64'd0);

      // Fairness: all four held, mode i for requester i, ptr back at 0.
      do_reset();
      bus.req      = 4'b1111;
      bus.req_mode = 8'hE4;
      for (int g = 0; g < 8; g++) begin
         serve("fair", 4'(1 << (g % 4)), 2'(g % 4), 64'h1000 + 64'(g));
      end
      bus.req = 4'b0000;
      chk("fair.samp", 64'(samp_cnt), 64'd8);

      // Timeout on requester 1 (ptr=0): silent generator.
      tick();
      bus.req = 4'b0010;
      tick();
      chk("tmo.gen_req", 64'(bus.gen_req), 64'd1);
      repeat (64) tick();
      chk("tmo.gnt_early", 64'(bus.gnt), 64'd0);
      tick();
      chk("tmo.gnt", 64'(bus.gnt), 64'b0010);
      chk("tmo.err", 64'(bus.rsp_err), 64'd1);
      chk("tmo.data", bus.rsp_data, 64'd0);
      bus.req = 4'b0000;
      tick();
      chk("tmo.cnt", 64'(tmo_cnt), 64'd1);
      chk("tmo.samp", 64'(samp_cnt), 64'd8);
      bus.gen_vld  = 1'b1;
      bus.gen_data = 64'hDEAD;
      tick();
      bus.gen_vld = 1'b0;
      chk("tmo.spur", 64'(spur_cnt), 64'd1);
      chk("tmo.spur_gnt", 64'(bus.gnt), 64'd0);
      bus.req = 4'b0100;
      serve("after_tmo", 4'b0100, 2'b10, 64'h4000000000000000);
      bus.req = 4'b0000;

      // Response on the expiry edge wins (ptr=3, req0 found by wrap).
      bus.req = 4'b0001;
      tick();
      chk("edge.gen_mode", 64'(bus.gen_mode), 64'd0);
      repeat (64) tick();
      bus.gen_vld  = 1'b1;
      bus.gen_data = 64'h0123456789ABCDEF;
      tick();
      bus.gen_vld = 1'b0;
      chk("edge.gnt", 64'(bus.gnt), 64'b0001);
      chk("edge.err", 64'(bus.rsp_err), 64'd0);
      chk("edge.data", bus.rsp_data, 64'h0123456789ABCDEF);
      bus.req = 4'b0000;
      tick();
      chk("edge.tmo", 64'(tmo_cnt), 64'd1);
      chk("edge.samp", 64'(samp_cnt), 64'd10);

      // Reset in the middle of WAIT for requester 3.
      bus.req = 4'b1000;
      repeat (3) tick();
      chk("mid.busy_pre", 64'(busy), 64'd1);
      rstb    = 1'b0;
      bus.req = 4'b0000;
      #1;
      chk("mid.busy", 64'(busy), 64'd0);
      chk("mid.samp", 64'(samp_cnt), 64'd0);
      chk("mid.tmo", 64'(tmo_cnt), 64'd0);
      tick();
      rstb        = 1'b1;
      bus.gen_vld = 1'b1;
      tick();
      bus.gen_vld = 1'b0;
      chk("mid.spur", 64'(spur_cnt), 64'd1);
      chk("mid.gnt", 64'(bus.gnt), 64'd0);
      chk("mid.idle", 64'(busy), 64'd0);
      bus.req = 4'b1001;
      serve("mid.r0", 4'b0001, 2'b00, 64'h55);
      bus.req = 4'b1000;
      serve("mid.r3", 4'b1000, 2'b11, 64'h66);
      bus.req = 4'b0000;

      // Short pulse on req[1] while serving requester 0 is never granted.
      bus.req = 4'b0001;
      tick();
      bus.req = 4'b0011;
      tick();
      bus.req      = 4'b0001;
      bus.gen_vld  = 1'b1;
      bus.gen_data = 64'h77;
      tick();
      bus.gen_vld = 1'b0;
      chk("pulse.gnt0", 64'(bus.gnt), 64'b0001);
      bus.req = 4'b0000;
      repeat (2) tick();
      chk("pulse.busy", 64'(busy), 64'd0);
      chk("pulse.gen_req", 64'(bus.gen_req), 64'd0);

      // Mode change and req drop after selection of requester 3.
      bus.req = 4'b1000;
      tick();
      bus.req_mode = 8'h24;
      chk("mode.gen_mode", 64'(bus.gen_mode), 64'd3);
      tick();
      bus.req      = 4'b0000;
      bus.gen_vld  = 1'b1;
      bus.gen_data = 64'h88;
      tick();
      bus.gen_vld = 1'b0;
      chk("mode.gnt", 64'(bus.gnt), 64'b1000);
      chk("mode.data", bus.rsp_data, 64'h88);
      tick();
      chk("mode.samp", 64'(samp_cnt), 64'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/noise_req_arbiter.md
Name: noise_req_arbiter

Overview:
- Shares one noise-sample generator among N_REQ requesters: urand, randn, bounded randn and flicker sources behind a single request/valid port.
- Round-robin arbitration, one outstanding generator transaction at a time.
- Returns each sample to the granted requester with a one-cycle grant pulse.
- Sits between per-channel noise consumers (jitter/offset injectors) and the shared generator wrapper.
- Keeps sample, timeout and spurious-response statistics for the sample dump path.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DW, 64, sample width (IEEE-754 double bit pattern).
- TIMEOUT, 64, max cycles spent in WAIT before error completion (>=2).
- CW, 32, width of sample/timeout counters.

Ports:
- clk  in  1  clock.
- rstb  in  1  async active-low reset.
- req  in  N_REQ  level request per requester; held until its gnt bit pulses.
- req_mode  in  2*N_REQ  per-requester mode, bits [2i+1:2i]: 00 urand, 01 randn, 10 randn_bnd, 11 flicker.
- gnt  out  N_REQ  one-hot, one-cycle response strobe.
- rsp_data  out  DW  sample, valid while gnt!=0.
- rsp_err  out  1  timeout flag, valid while gnt!=0.
- gen_req  out  1  one-cycle generator request.
- gen_mode  out  2  mode for gen_req.
- gen_vld  in  1  generator response strobe.
- gen_data  in  DW  generator sample, valid with gen_vld.
- busy  out  1  state != IDLE.
- samp_cnt  out  CW  successful deliveries, wraps.
- tmo_cnt  out  CW  timeout completions, saturating.
- spur_cnt  out  8  gen_vld outside WAIT, saturating at 255.

Behaviour:
- Reset (async, rstb=0): state IDLE, ptr=0, all outputs 0, all counters 0. Reset mid-transaction abandons it; no gnt is issued.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - If req!=0 at the clock edge, select the first set bit searching ptr, ptr+1, … mod N_REQ.
  - Latch idx and its mode, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: gen_req=1, gen_mode=latched mode for exactly this cycle; clear timer; go to WAIT.
- WAIT:
  - gen_vld=1: capture gen_data, err=0, go to DELIVER.
  - Else timer++. When timer reaches TIMEOUT-1 without gen_vld: data=0, err=1, go to DELIVER.
  - If gen_vld and expiry occur on the same edge, gen_vld wins (err=0).
- DELIVER:
  - gnt[idx]=1, rsp_data/rsp_err driven from the capture registers.
  - samp_cnt++ if err=0, else tmo_cnt++ (saturating).
  - ptr <= (idx+1) mod N_REQ.
  - Next state IDLE.
- Outside DELIVER: gnt=0, rsp_data=0, rsp_err=0.
- Minimum latency: req seen at edge k → gen_req in cycle k+1 → gen_vld earliest in cycle k+2 → gnt in cycle k+3. Back-to-back service gives one grant per 4 cycles.
- Request mode is sampled only at the IDLE selection edge. Later req_mode changes have no effect on the in-flight transaction.
- A requester dropping req after selection still receives its gnt.
- A requester dropping req before selection is simply not served.
- gen_vld in IDLE, ISSUE or DELIVER: data discarded, spur_cnt++ (saturating). This includes late responses after a timeout and responses that arrive after a reset.
- ptr advances only on DELIVER, so a timed-out requester also loses priority.
- Arbitration and counters are pure integer logic; no real arithmetic in the block.

Test Plan:
- Single requester: req[2]=1, mode=01, generator returns 0x3FF0000000000000 one cycle after gen_req → gnt=4'b0100 exactly 3 cycles after req edge, rsp_data=0x3FF0000000000000, rsp_err=0, samp_cnt=1.
- Fairness: req=4'b1111 held, 1-cycle generator → grant order 0,1,2,3,0,1,… one gnt every 4 cycles; gen_mode matches each requester's mode; samp_cnt=8 after 8 grants.
- Timeout: TIMEOUT=64, generator silent → gnt after ISSUE+64 WAIT cycles with rsp_err=1, rsp_data=0, tmo_cnt=1. A later gen_vld increments spur_cnt to 1, and the next requester is served normally.
- Simultaneous edge: gen_vld asserted on the timer-expiry edge → rsp_err=0, data delivered, tmo_cnt unchanged.
- Reset mid-WAIT: assert rstb=0 during WAIT → all outputs 0 immediately; after release, the stale gen_vld gives spur_cnt=1 and no gnt; ptr=0, so req=4'b1001 grants requester 0 first.
- Request drop/mode change: req[1] pulses for 1 cycle while busy serving 0 → never granted; req_mode[3] changed during WAIT of requester 3 → gen_mode reflects the old value.
